// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle RV64I control FSM; optional retired-instruction counter under CU_INSTRET_EN
module control_unit #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       run,
    input  logic [6:0] opcode,
    output logic       load_ir,
    output logic       load_pc,
    output logic       pc_next_sel,
    output logic       pc_adder_sel,
    output logic       WE_RF,
    output logic       WE_MEM,
    output logic [1:0] RF_din_sel,
    output logic       ULA_din2_sel,
    output logic       illegal,
    output logic       busy
`ifdef CU_INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);

    typedef enum logic [2:0] {
        IDLE      = RESET_STATE,
        FETCH     = RESET_STATE + 3'd1,
        DECODE    = RESET_STATE + 3'd2,
        EXECUTE   = RESET_STATE + 3'd3,
        MEMORY    = RESET_STATE + 3'd4,
        WRITEBACK = RESET_STATE + 3'd5,
        TRAP      = RESET_STATE + 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t     state;
    state_t     next_state;
    logic       supported;
    logic       uses_imm;
    logic       last_cycle;
    logic       n_load_ir;
    logic       n_load_pc;
    logic       n_pc_next_sel;
    logic       n_pc_adder_sel;
    logic       n_we_rf;
    logic       n_we_mem;
    logic [1:0] n_rf_din_sel;
    logic       n_ula_din2_sel;

    always_comb begin
        supported = opcode inside {OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE,
                                   OP_BRANCH, OP_AUIPC, OP_JAL, OP_JALR};
        uses_imm  = opcode inside {OP_I, OP_LOAD, OP_STORE, OP_LUI};
        last_cycle = (state == EXECUTE && opcode == OP_BRANCH) ||
                     (state == MEMORY && opcode == OP_STORE) ||
                     (state == WRITEBACK);

        next_state = state;
        case (state)
            IDLE:      if (run) next_state = FETCH;
            FETCH:     next_state = DECODE;
            DECODE:    next_state = supported ? EXECUTE : TRAP;
            EXECUTE:   if (opcode == OP_BRANCH)            next_state = run ? FETCH : IDLE;
                       else if (opcode == OP_LOAD || opcode == OP_STORE) next_state = MEMORY;
                       else                                next_state = WRITEBACK;
            MEMORY:    if (opcode == OP_STORE) next_state = run ? FETCH : IDLE;
                       else                    next_state = WRITEBACK;
            WRITEBACK: next_state = run ? FETCH : IDLE;
            TRAP:      next_state = TRAP;
            default:   next_state = IDLE;
        endcase

        // Strobes are computed for the state being entered so they register in step with it;
        // the IR (and so opcode) is already stable whenever an opcode-dependent state is entered.
        n_load_ir      = 1'b0;
        n_load_pc      = 1'b0;
        n_pc_next_sel  = 1'b0;
        n_pc_adder_sel = 1'b0;
        n_we_rf        = 1'b0;
        n_we_mem       = 1'b0;
        n_rf_din_sel   = 2'b00;
        n_ula_din2_sel = 1'b0;
        case (next_state)
            FETCH: n_load_ir = 1'b1;
            EXECUTE: begin
                n_ula_din2_sel = uses_imm;
                if (opcode == OP_BRANCH) begin
                    n_load_pc     = 1'b1;
                    n_pc_next_sel = 1'b1;
                end
            end
            MEMORY: begin
                n_ula_din2_sel = uses_imm;
                if (opcode == OP_STORE) begin
                    n_we_mem  = 1'b1;
                    n_load_pc = 1'b1;
                end
            end
            WRITEBACK: begin
                n_ula_din2_sel = uses_imm;
                n_we_rf        = 1'b1;
                n_load_pc      = 1'b1;
                case (opcode)
                    OP_R, OP_I, OP_LUI: n_rf_din_sel = 2'b01;
                    OP_AUIPC:           n_rf_din_sel = 2'b11;
                    OP_JAL: begin
                        n_rf_din_sel  = 2'b10;
                        n_pc_next_sel = 1'b1;
                    end
                    OP_JALR: begin
                        n_rf_din_sel   = 2'b10;
                        n_pc_next_sel  = 1'b1;
                        n_pc_adder_sel = 1'b1;
                    end
                    default:            n_rf_din_sel = 2'b00;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            load_ir      <= 1'b0;
            load_pc      <= 1'b0;
            pc_next_sel  <= 1'b0;
            pc_adder_sel <= 1'b0;
            WE_RF        <= 1'b0;
            WE_MEM       <= 1'b0;
            RF_din_sel   <= 2'b00;
            ULA_din2_sel <= 1'b0;
            illegal      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= next_state;
            load_ir      <= n_load_ir;
            load_pc      <= n_load_pc;
            pc_next_sel  <= n_pc_next_sel;
            pc_adder_sel <= n_pc_adder_sel;
            WE_RF        <= n_we_rf;
            WE_MEM       <= n_we_mem;
            RF_din_sel   <= n_rf_din_sel;
            ULA_din2_sel <= n_ula_din2_sel;
            illegal      <= (next_state == TRAP);
            busy         <= !(next_state inside {IDLE, TRAP});
        end
    end

`ifdef CU_INSTRET_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)           instret <= 64'd0;
        else if (last_cycle) instret <= instret + 64'd1;
    end
`endif

endmodule
